rconfig_seq_ctrl: RTL
=====================

# rconfig_seq_ctrl

Sequencer for R-configuration-driven streaming accesses. It captures a four-word R-configuration record (command, length, stride, base) from the configuration stream and then issues `Length` addresses `Base + i*Stride` over a valid/ack handshake to the memory port. It sits between the configuration network and a CRAM access port. It is the controller that consumes the stored R-config and sequences the access it describes.

## Interface
Parameters:
- `WIDTH_DATA`, 32: configuration word width.
- `WIDTH_ADDR`, 16: generated address width; must be ≤ `WIDTH_DATA`.

Ports:
- `clock` in, 1: clock.
- `reset` in, 1: reset, asynchronous, active-high.
- `I_Clr` in, 1: synchronous abort/clear, highest priority after reset.
- `I_Valid` in, 1: configuration word valid.
- `I_Data` in, `WIDTH_DATA`: configuration word, arriving in order word0=command, word1=length, word2=stride, word3=base.
- `O_Ready` out, 1: configuration word accepted this cycle when `I_Valid & O_Ready`.
- `O_Req` out, 1: address request valid.
- `I_Ack` in, 1: address consumed when `O_Req & I_Ack`.
- `O_Addr` out, `WIDTH_ADDR`: current address.
- `O_Cmd` out, `WIDTH_DATA`: captured command word, held until the next record load.
- `O_Busy` out, 1: high while in RUN.
- `O_Done` out, 1: one-cycle pulse at sequence completion.
- `O_Err` out, 1: sticky zero-length error; cleared by `I_Clr` or by the next accepted word0.

## Operation
States:
- **LOAD**: `O_Ready=1`. A 2-bit word index advances on each accept, and each word is stored into command, length, stride or base. On accepting word3: if length==0, set `O_Err` and go to DONE; otherwise set addr=base[`WIDTH_ADDR`-1:0] and remain=length, then go to RUN.
- **RUN**: `O_Req=1`, `O_Addr=addr`. On ack: if remain==1, go to DONE; otherwise addr += stride[`WIDTH_ADDR`-1:0] modulo 2^`WIDTH_ADDR` (two's complement, so negative strides are valid) and remain -= 1. Without ack, `O_Addr` holds stable.
- **DONE**: `O_Done=1` for exactly one cycle, then go to LOAD with word index 0.

Rules:
- remain is `WIDTH_DATA` bits wide. Length is unsigned and all `WIDTH_DATA` bits are significant.
- `I_Clr` in any state returns to LOAD with index 0. No `O_Done` pulse is issued. `O_Req` drops the next cycle. `O_Cmd` is retained.
- `I_Clr` together with an accept or ack in the same cycle: the clear wins and the word or ack is discarded.
- Reset values: state LOAD, index 0, all registers 0. `O_Ready=1`, `O_Req=0`, `O_Addr=0`, `O_Cmd=0`, `O_Busy=0`, `O_Done=0`, `O_Err=0`.

## Timing
- Accepting word3 in cycle t gives `O_Req=1` with `O_Addr`=base in cycle t+1.
- With `I_Ack` held high, the block issues one address per cycle.
- The last ack in cycle t gives `O_Done=1` in t+1. `O_Ready=1` from t+2.
- The zero-length case: accepting word3 in cycle t gives `O_Err=1` and `O_Done=1` in t+1.
- All outputs are registered or decoded from registered state. There is no combinational path from `I_Valid`/`I_Ack` to `O_Req`/`O_Ready`.

## Configuration
- Macro `RCFG_SEQ_REPEAT_EN`.
- Defined: command bit `WIDTH_DATA`-1 = repeat. After the last ack of a pass, addr reloads to base and remain reloads to length, and the block stays in RUN with no bubble. `O_Done` pulses for one cycle, coincident with the first `O_Req` of the next pass. The block exits only via `I_Clr`.
- Undefined: bit `WIDTH_DATA`-1 is ignored and is captured into `O_Cmd` only. Behaviour is as in Operation.

## Structure
- Package `rcfg_seq_pkg`: state enum (`ST_LOAD`, `ST_RUN`, `ST_DONE`), word-index constants (`IDX_CMD`=0, `IDX_LEN`=1, `IDX_STRIDE`=2, `IDX_BASE`=3), and the repeat-bit position.
- Sub-module `rcfg_seq_agu`: holds the addr/remain registers, with load, step and last outputs.
- The FSM, capture registers and handshake logic live in the top module.

## Test plan
- Record {cmd=0, len=4, stride=4, base=0x100} with ack held high -> addresses 0x100, 0x104, 0x108, 0x10C on consecutive cycles, then one `O_Done` pulse, then `O_Ready`=1.
- len=3, stride=0xFFFF (−1), base=0x0001 -> addresses 0x0001, 0x0000, 0xFFFF (wrap).
- len=2 with ack toggling 1,0,1 -> `O_Addr` held stable through the stalled cycle, exactly 2 addresses, `O_Done` after the second ack.
- len=0 -> no `O_Req`; `O_Err`=1 and `O_Done`=1 one cycle after word3; `O_Err` cleared by the next word0.
- `I_Clr` asserted after 2 of 5 acks -> `O_Req` low the next cycle, no `O_Done`; a new record loads normally. `reset` asserted mid-RUN -> all outputs return to reset values immediately.
- `RCFG_SEQ_REPEAT_EN` defined, cmd bit31=1, len=2, base=0x10, stride=1 -> 0x10, 0x11, 0x10, 0x11, … with `O_Done` at each pass boundary; stops only on `I_Clr`.

Source files
------------

// File: rtl/rcfg_seq_pkg.sv
// rcfg_seq_pkg
// Shared definitions for the R-configuration sequencer: FSM state encoding,
// configuration word indices and the position of the repeat flag in the
// command word. No ports.
package rcfg_seq_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] IDX_CMD    = 2'd0;
    localparam logic [1:0] IDX_LEN    = 2'd1;
    localparam logic [1:0] IDX_STRIDE = 2'd2;
    localparam logic [1:0] IDX_BASE   = 2'd3;

    // Repeat flag is the MSB of the command word.
    function automatic int unsigned repeat_bit(input int unsigned width_data);
        return width_data - 1;
    endfunction

endpackage

// File: rtl/rcfg_seq_agu.sv
// rcfg_seq_agu
// Address generator for the sequencer: holds the current address and the
// number of addresses still to issue.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset
//   load           : addr <= base, remain <= length
//   step           : addr += stride (mod 2^WIDTH_ADDR), remain -= 1
//   base, stride   : address start / increment (two's complement)
//   length         : number of addresses in one pass
//   addr           : current address
//   last           : remain == 1 (current address is the final one)
module rcfg_seq_agu #(
    parameter int unsigned WIDTH_DATA = 32,
    parameter int unsigned WIDTH_ADDR = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [WIDTH_ADDR-1:0] base,
    input  logic [WIDTH_ADDR-1:0] stride,
    input  logic [WIDTH_DATA-1:0] length,
    output logic [WIDTH_ADDR-1:0] addr,
    output logic                  last
);

    logic [WIDTH_ADDR-1:0] addr_q;
    logic [WIDTH_DATA-1:0] remain_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            remain_q <= '0;
        end else if (load) begin
            addr_q   <= base;
            remain_q <= length;
        end else if (step) begin
            addr_q   <= addr_q + stride;
            remain_q <= remain_q - WIDTH_DATA'(1);
        end
    end

    assign addr = addr_q;
    assign last = (remain_q == WIDTH_DATA'(1));

endmodule

// File: rtl/rconfig_seq_ctrl.sv
// rconfig_seq_ctrl
// Captures a four-word R-configuration record (command, length, stride,
// base) and then issues Length addresses Base + i*Stride over a req/ack
// handshake.
// Optional feature: define RCFG_SEQ_REPEAT_EN to honour the repeat flag in
// command bit WIDTH_DATA-1 (sequence restarts indefinitely until I_Clr).
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   I_Clr        : synchronous abort back to LOAD (no done pulse)
//   I_Valid/I_Data/O_Ready : configuration word stream
//   O_Req/I_Ack/O_Addr     : address request handshake
//   O_Cmd        : captured command word
//   O_Busy       : sequence running
//   O_Done       : one-cycle completion pulse
//   O_Err        : sticky zero-length error
module rconfig_seq_ctrl
    import rcfg_seq_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = 32,
    parameter int unsigned WIDTH_ADDR = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Clr,
    input  logic                  I_Valid,
    input  logic [WIDTH_DATA-1:0] I_Data,
    output logic                  O_Ready,
    output logic                  O_Req,
    input  logic                  I_Ack,
    output logic [WIDTH_ADDR-1:0] O_Addr,
    output logic [WIDTH_DATA-1:0] O_Cmd,
    output logic                  O_Busy,
    output logic                  O_Done,
    output logic                  O_Err
);

    state_t                state_q;
    logic [1:0]            idx_q;
    logic [WIDTH_DATA-1:0] cmd_q;
    logic [WIDTH_DATA-1:0] len_q;
    logic [WIDTH_ADDR-1:0] stride_q;
    logic [WIDTH_ADDR-1:0] base_q;
    logic                  done_q;
    logic                  err_q;

    logic                  repeat_on;
    logic                  accept;
    logic                  ack;
    logic                  last;
    logic                  agu_load;
    logic                  agu_step;
    logic [WIDTH_ADDR-1:0] agu_base;

`ifdef RCFG_SEQ_REPEAT_EN
    localparam int unsigned RPT_BIT = repeat_bit(WIDTH_DATA);
    assign repeat_on = cmd_q[RPT_BIT];
`else
    assign repeat_on = 1'b0;
`endif

    assign accept = (state_q == ST_LOAD) && I_Valid && !I_Clr;
    assign ack    = (state_q == ST_RUN) && I_Ack && !I_Clr;

    // Base comes straight from the bus on the word3 accept (it is not yet
    // in base_q); a repeat reload uses the stored copy.
    assign agu_base = (state_q == ST_LOAD) ? I_Data[WIDTH_ADDR-1:0] : base_q;
    assign agu_load = (accept && idx_q == IDX_BASE && len_q != '0)
                    || (ack && last && repeat_on);
    assign agu_step = ack && !last;

    rcfg_seq_agu #(
        .WIDTH_DATA(WIDTH_DATA),
        .WIDTH_ADDR(WIDTH_ADDR)
    ) u_agu (
        .clock  (clock),
        .reset  (reset),
        .load   (agu_load),
        .step   (agu_step),
        .base   (agu_base),
        .stride (stride_q),
        .length (len_q),
        .addr   (O_Addr),
        .last   (last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_LOAD;
            idx_q    <= IDX_CMD;
            cmd_q    <= '0;
            len_q    <= '0;
            stride_q <= '0;
            base_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (I_Clr) begin
                state_q <= ST_LOAD;
                idx_q   <= IDX_CMD;
                err_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        if (I_Valid) begin
                            idx_q <= idx_q + 2'd1;
                            case (idx_q)
                                IDX_CMD: begin
                                    cmd_q <= I_Data;
                                    err_q <= 1'b0;
                                end
                                IDX_LEN:    len_q    <= I_Data;
                                IDX_STRIDE: stride_q <= I_Data[WIDTH_ADDR-1:0];
                                default: begin
                                    base_q <= I_Data[WIDTH_ADDR-1:0];
                                    if (len_q == '0) begin
                                        err_q   <= 1'b1;
                                        done_q  <= 1'b1;
                                        state_q <= ST_DONE;
                                    end else begin
                                        state_q <= ST_RUN;
                                    end
                                end
                            endcase
                        end
                    end
                    ST_RUN: begin
                        if (I_Ack && last) begin
                            done_q <= 1'b1;
                            // Repeat mode reloads the AGU and stays in RUN.
                            if (!repeat_on) begin
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_LOAD;
                        idx_q   <= IDX_CMD;
                    end
                endcase
            end
        end
    end

    assign O_Ready = (state_q == ST_LOAD);
    assign O_Req   = (state_q == ST_RUN);
    assign O_Busy  = (state_q == ST_RUN);
    assign O_Cmd   = cmd_q;
    assign O_Done  = done_q;
    assign O_Err   = err_q;

endmodule
